// File: rtl/nx_node_decoder.sv
// Inbound message decoder for a mesh node: local messages become single-cycle
// strobes, everything else is routed one hop onward through a registered bypass.
module nx_node_decoder #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int INPUTS         = 8,
    parameter int OUTPUTS        = 8,
    parameter int MAX_IO         = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS,
    parameter int PAYLOAD_WIDTH  = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0]   node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0]   node_col_i,
    input  logic [STREAM_WIDTH-1:0]     msg_data_i,
    input  logic                        msg_valid_i,
    output logic                        msg_ready_o,
    output logic [STREAM_WIDTH-1:0]     byp_data_o,
    output logic [1:0]                  byp_dir_o,
    output logic                        byp_valid_o,
    input  logic                        byp_ready_i,
    output logic [$clog2(MAX_IO)-1:0]   map_io_o,
    output logic                        map_input_o,
    output logic [ADDR_ROW_WIDTH-1:0]   map_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0]   map_remote_col_o,
    output logic [$clog2(OUTPUTS)-1:0]  map_remote_idx_o,
    output logic                        map_slot_o,
    output logic                        map_broadcast_o,
    output logic                        map_seq_o,
    output logic                        map_valid_o,
    output logic [ADDR_ROW_WIDTH-1:0]   signal_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0]   signal_remote_col_o,
    output logic [$clog2(OUTPUTS)-1:0]  signal_remote_idx_o,
    output logic                        signal_state_o,
    output logic                        signal_valid_o,
    output logic                        trigger_o,
    output logic [PAYLOAD_WIDTH-1:0]    instr_data_o,
    output logic                        instr_valid_o
);
    localparam int IO_W  = $clog2(MAX_IO);
    localparam int IDX_W = $clog2(OUTPUTS);
    localparam int RW    = ADDR_ROW_WIDTH;
    localparam int CW    = ADDR_COL_WIDTH;
    localparam int PW    = PAYLOAD_WIDTH;

    localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD_INSTR = COMMAND_WIDTH'(0);
    localparam logic [COMMAND_WIDTH-1:0] CMD_CFG_IO     = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] CMD_SIG_STATE  = COMMAND_WIDTH'(2);
    localparam logic [COMMAND_WIDTH-1:0] CMD_CONTROL    = COMMAND_WIDTH'(3);

    localparam logic [1:0] DIRX_NORTH = 2'd0;
    localparam logic [1:0] DIRX_EAST  = 2'd1;
    localparam logic [1:0] DIRX_SOUTH = 2'd2;
    localparam logic [1:0] DIRX_WEST  = 2'd3;

    // Payload field positions, packed MSB first with zero pad at the bottom
    localparam int S_ROW = PW - 1;
    localparam int S_COL = S_ROW - RW;
    localparam int S_IDX = S_COL - CW;
    localparam int S_ST  = S_IDX - IDX_W;
    localparam int C_IO  = PW - 1;
    localparam int C_INP = C_IO - IO_W;
    localparam int C_ROW = C_INP - 1;
    localparam int C_COL = C_ROW - RW;
    localparam int C_IDX = C_COL - CW;
    localparam int C_SLT = C_IDX - IDX_W;
    localparam int C_BC  = C_SLT - 1;
    localparam int C_SEQ = C_BC - 1;

    logic                     w_bc;
    logic [RW-1:0]            w_tgt_row;
    logic [CW-1:0]            w_tgt_col;
    logic [COMMAND_WIDTH-1:0] w_cmd;
    logic [PW-1:0]            w_payload;
    logic                     w_local;
    logic                     w_xfer;
    logic [1:0]               w_dir;

    logic [STREAM_WIDTH-1:0]  r_byp_data;
    logic [1:0]               r_byp_dir;
    logic                     r_byp_valid;

    assign {w_bc, w_tgt_row, w_tgt_col, w_cmd, w_payload} = msg_data_i;
    assign w_local     = w_bc || (w_tgt_row == node_row_i && w_tgt_col == node_col_i);
    assign msg_ready_o = !rst_i && (!r_byp_valid || byp_ready_i);
    assign w_xfer      = msg_valid_i && msg_ready_o;

    always_comb begin
        w_dir = DIRX_EAST;
        if (w_tgt_row < node_row_i)      w_dir = DIRX_NORTH;
        else if (w_tgt_row > node_row_i) w_dir = DIRX_SOUTH;
        else if (w_tgt_col < node_col_i) w_dir = DIRX_WEST;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_byp_data          <= '0;
            r_byp_dir           <= DIRX_NORTH;
            r_byp_valid         <= 1'b0;
            map_io_o            <= '0;
            map_input_o         <= 1'b0;
            map_remote_row_o    <= '0;
            map_remote_col_o    <= '0;
            map_remote_idx_o    <= '0;
            map_slot_o          <= 1'b0;
            map_broadcast_o     <= 1'b0;
            map_seq_o           <= 1'b0;
            map_valid_o         <= 1'b0;
            signal_remote_row_o <= '0;
            signal_remote_col_o <= '0;
            signal_remote_idx_o <= '0;
            signal_state_o      <= 1'b0;
            signal_valid_o      <= 1'b0;
            trigger_o           <= 1'b0;
            instr_data_o        <= '0;
            instr_valid_o       <= 1'b0;
        end else begin
            map_valid_o    <= 1'b0;
            signal_valid_o <= 1'b0;
            trigger_o      <= 1'b0;
            instr_valid_o  <= 1'b0;

            if (w_xfer && w_local) begin
                case (w_cmd)
                    CMD_SIG_STATE: begin
                        signal_remote_row_o <= w_payload[S_ROW -: RW];
                        signal_remote_col_o <= w_payload[S_COL -: CW];
                        signal_remote_idx_o <= w_payload[S_IDX -: IDX_W];
                        signal_state_o      <= w_payload[S_ST];
                        signal_valid_o      <= 1'b1;
                    end
                    CMD_CFG_IO: begin
                        map_io_o         <= w_payload[C_IO -: IO_W];
                        map_input_o      <= w_payload[C_INP];
                        map_remote_row_o <= w_payload[C_ROW -: RW];
                        map_remote_col_o <= w_payload[C_COL -: CW];
                        map_remote_idx_o <= w_payload[C_IDX -: IDX_W];
                        map_slot_o       <= w_payload[C_SLT];
                        map_broadcast_o  <= w_payload[C_BC];
                        map_seq_o        <= w_payload[C_SEQ];
                        map_valid_o      <= 1'b1;
                    end
                    CMD_LOAD_INSTR: begin
                        instr_data_o  <= w_payload;
                        instr_valid_o <= 1'b1;
                    end
                    CMD_CONTROL: trigger_o <= w_payload[0];
                    default: ;
                endcase
            end

            // A drain and a new load in the same cycle leave valid high: no bubble
            if (w_xfer && !w_local) begin
                r_byp_data  <= msg_data_i;
                r_byp_dir   <= w_dir;
                r_byp_valid <= 1'b1;
            end else if (byp_ready_i) begin
                r_byp_valid <= 1'b0;
            end
        end
    end

    assign byp_data_o  = r_byp_data;
    assign byp_dir_o   = r_byp_dir;
    assign byp_valid_o = r_byp_valid;
endmodule

// File: tb/tb_nx_node_decoder.sv
// Self-checking bench for nx_node_decoder: directed scenarios followed by
// randomized traffic, all checked against a message-level reference model.
module tb_nx_node_decoder;
    localparam int PW = 21;

    logic        clk_i = 0;
    logic        rst_i;
    logic [3:0]  node_row_i, node_col_i;
    logic [31:0] msg_data_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [31:0] byp_data_o;
    logic [1:0]  byp_dir_o;
    logic        byp_valid_o;
    logic        byp_ready_i;
    logic [2:0]  map_io_o;
    logic        map_input_o;
    logic [3:0]  map_remote_row_o, map_remote_col_o;
    logic [2:0]  map_remote_idx_o;
    logic        map_slot_o, map_broadcast_o, map_seq_o, map_valid_o;
    logic [3:0]  signal_remote_row_o, signal_remote_col_o;
    logic [2:0]  signal_remote_idx_o;
    logic        signal_state_o, signal_valid_o, trigger_o;
    logic [20:0] instr_data_o;
    logic        instr_valid_o;

    nx_node_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i), .node_row_i(node_row_i), .node_col_i(node_col_i),
        .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .byp_data_o(byp_data_o), .byp_dir_o(byp_dir_o), .byp_valid_o(byp_valid_o),
        .byp_ready_i(byp_ready_i),
        .map_io_o(map_io_o), .map_input_o(map_input_o), .map_remote_row_o(map_remote_row_o),
        .map_remote_col_o(map_remote_col_o), .map_remote_idx_o(map_remote_idx_o),
        .map_slot_o(map_slot_o), .map_broadcast_o(map_broadcast_o), .map_seq_o(map_seq_o),
        .map_valid_o(map_valid_o),
        .signal_remote_row_o(signal_remote_row_o), .signal_remote_col_o(signal_remote_col_o),
        .signal_remote_idx_o(signal_remote_idx_o), .signal_state_o(signal_state_o),
        .signal_valid_o(signal_valid_o), .trigger_o(trigger_o),
        .instr_data_o(instr_data_o), .instr_valid_o(instr_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: what each output should read after the next edge
    longint m_bv, m_bd, m_bdir;
    longint m_mv, m_io, m_inp, m_mrow, m_mcol, m_midx, m_slot, m_mbc, m_seq;
    longint m_sv, m_srow, m_scol, m_sidx, m_sst;
    longint m_trig, m_iv, m_instr;

    function automatic longint fld(input longint pl, input int pos, input int w);
        return (pl >> (PW - pos - w)) % (longint'(1) << w);
    endfunction

    function automatic logic [31:0] mk(input int bc, input int r, input int c,
                                       input int cmd, input int pl);
        return (32'(bc) << 31) | (32'(r) << 27) | (32'(c) << 23) | (32'(cmd) << 21) | 32'(pl % (1 << PW));
    endfunction

    task automatic model_reset();
        m_bv = 0; m_bd = 0; m_bdir = 0;
        m_mv = 0; m_io = 0; m_inp = 0; m_mrow = 0; m_mcol = 0; m_midx = 0;
        m_slot = 0; m_mbc = 0; m_seq = 0;
        m_sv = 0; m_srow = 0; m_scol = 0; m_sidx = 0; m_sst = 0;
        m_trig = 0; m_iv = 0; m_instr = 0;
    endtask

    task automatic model_msg(input longint d);
        longint bc, tr, tc, cmd, pl, nr, nc;
        bc = d >> 31; tr = (d >> 27) % 16; tc = (d >> 23) % 16;
        cmd = (d >> 21) % 4; pl = d % (longint'(1) << PW);
        nr = node_row_i; nc = node_col_i;
        if (bc == 1 || (tr == nr && tc == nc)) begin
            if (cmd == 2) begin
                m_sv = 1; m_srow = fld(pl, 0, 4); m_scol = fld(pl, 4, 4);
                m_sidx = fld(pl, 8, 3); m_sst = fld(pl, 11, 1);
            end else if (cmd == 1) begin
                m_mv = 1; m_io = fld(pl, 0, 3); m_inp = fld(pl, 3, 1);
                m_mrow = fld(pl, 4, 4); m_mcol = fld(pl, 8, 4); m_midx = fld(pl, 12, 3);
                m_slot = fld(pl, 15, 1); m_mbc = fld(pl, 16, 1); m_seq = fld(pl, 17, 1);
            end else if (cmd == 0) begin
                m_iv = 1; m_instr = pl;
            end else begin
                m_trig = pl % 2;
            end
        end else begin
            m_bv = 1; m_bd = d;
            if (tr < nr)      m_bdir = 0;
            else if (tr > nr) m_bdir = 2;
            else if (tc < nc) m_bdir = 3;
            else              m_bdir = 1;
        end
    endtask

    task automatic compare_all();
        chk("byp_valid", byp_valid_o, m_bv);
        chk("byp_data", byp_data_o, m_bd);
        chk("byp_dir", byp_dir_o, m_bdir);
        chk("map_valid", map_valid_o, m_mv);
        chk("map_io", map_io_o, m_io);
        chk("map_input", map_input_o, m_inp);
        chk("map_row", map_remote_row_o, m_mrow);
        chk("map_col", map_remote_col_o, m_mcol);
        chk("map_idx", map_remote_idx_o, m_midx);
        chk("map_slot", map_slot_o, m_slot);
        chk("map_bc", map_broadcast_o, m_mbc);
        chk("map_seq", map_seq_o, m_seq);
        chk("sig_valid", signal_valid_o, m_sv);
        chk("sig_row", signal_remote_row_o, m_srow);
        chk("sig_col", signal_remote_col_o, m_scol);
        chk("sig_idx", signal_remote_idx_o, m_sidx);
        chk("sig_state", signal_state_o, m_sst);
        chk("trigger", trigger_o, m_trig);
        chk("instr_valid", instr_valid_o, m_iv);
        chk("instr_data", instr_data_o, m_instr);
    endtask

    // One clock: drive after the falling edge, predict, then check at the next falling edge
    task automatic step(input logic rst, input logic v, input logic [31:0] d, input logic br);
        longint exp_rdy;
        rst_i = rst; msg_valid_i = v; msg_data_i = d; byp_ready_i = br;
        #1;
        exp_rdy = (!rst && (m_bv == 0 || br)) ? 1 : 0;
        chk("msg_ready", msg_ready_o, exp_rdy);
        if (rst) begin
            model_reset();
        end else begin
            m_mv = 0; m_sv = 0; m_trig = 0; m_iv = 0;
            if (br) m_bv = 0;
            if (v && exp_rdy == 1) model_msg(longint'(d));
        end
        @(negedge clk_i);
        compare_all();
    endtask

    logic [31:0] held;
    int cnt;

    initial begin
        node_row_i = 4'd2; node_col_i = 4'd3;
        model_reset();
        rst_i = 1; msg_valid_i = 0; msg_data_i = '0; byp_ready_i = 1;
        @(negedge clk_i);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);

        // Signal update from the worked example
        step(0, 1, 32'h11C27600, 1);
        chk("ex_sig_valid", signal_valid_o, 1);
        chk("ex_sig_row", signal_remote_row_o, 1);
        chk("ex_sig_col", signal_remote_col_o, 3);
        chk("ex_sig_idx", signal_remote_idx_o, 5);
        chk("ex_sig_state", signal_state_o, 1);
        chk("ex_no_byp", byp_valid_o, 0);

        // Forward directions
        step(0, 1, mk(0, 5, 3, 2, 12345), 1);
        chk("dir_south", byp_dir_o, 2);
        step(0, 1, mk(0, 2, 0, 2, 777), 1);
        chk("dir_west", byp_dir_o, 3);
        step(0, 1, mk(0, 2, 7, 2, 99), 1);
        chk("dir_east", byp_dir_o, 1);
        step(0, 1, mk(0, 0, 9, 0, 5), 1);
        chk("dir_north", byp_dir_o, 0);

        // Backpressure: stalled bypass blocks a following local message
        step(0, 1, mk(0, 7, 7, 3, 1), 1);
        held = byp_data_o;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, mk(0, 2, 3, 0, 21'h1ABCDE), 0);
            chk("bp_no_instr", instr_valid_o, 0);
            chk("bp_data_stable", byp_data_o, held);
        end
        step(0, 1, mk(0, 2, 3, 0, 21'h1ABCDE), 1);
        chk("bp_instr", instr_valid_o, 1);
        chk("bp_instr_data", instr_data_o, 21'h1ABCDE);

        // Neighbour broadcast with CFG_IO
        step(0, 1, mk(1, 0, 0, 1, (4 << 18) | (1 << 17) | (1 << 3)), 1);
        chk("bc_map_valid", map_valid_o, 1);
        chk("bc_map_io", map_io_o, 4);
        chk("bc_map_input", map_input_o, 1);
        chk("bc_map_seq", map_seq_o, 1);
        chk("bc_no_byp", byp_valid_o, 0);

        // Streaming without bubbles
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, mk(0, 9, i, 2, i * 1000 + 1), 1);
            if (byp_valid_o) cnt++;
        end
        chk("stream_cnt", cnt, 10);

        // Reset while a forwarded message is pending
        step(0, 1, mk(0, 9, 9, 1, 42), 0);
        chk("pre_rst_byp", byp_valid_o, 1);
        step(1, 1, mk(0, 2, 3, 3, 1), 0);
        chk("rst_byp_valid", byp_valid_o, 0);
        chk("rst_ready", msg_ready_o, 0);
        step(0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int bc, r, c;
            logic rst, v, br;
            if (i % 500 == 0 && msg_valid_i == 0) begin
                node_row_i = 4'($urandom_range(15));
                node_col_i = 4'($urandom_range(15));
            end
            bc  = ($urandom_range(7) == 0) ? 1 : 0;
            r   = ($urandom_range(2) == 0) ? int'(node_row_i) : int'($urandom_range(15));
            c   = ($urandom_range(2) == 0) ? int'(node_col_i) : int'($urandom_range(15));
            rst = ($urandom_range(199) == 0);
            v   = ($urandom_range(4) != 0);
            br  = ($urandom_range(3) != 0);
            step(rst, v, mk(bc, r, c, int'($urandom_range(3)), int'($urandom_range((1 << PW) - 1))), br);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nx_node_decoder.md
# nx_node_decoder

Inbound message decoder for a mesh node: the receive end of the node message protocol whose transmit end is the node controller's output state machine. It accepts one inbound message stream, which is already arbitrated across the four ports, and splits it two ways. Messages addressed to this node, or neighbour broadcasts, are decoded into single-cycle I/O-map, signal-state, trigger and instruction-load strobes. All other messages are routed one hop onward through a registered bypass output.

## Interface
Parameters:
- STREAM_WIDTH, 32, message width
- ADDR_ROW_WIDTH, 4, row address width
- ADDR_COL_WIDTH, 4, column address width
- COMMAND_WIDTH, 2, command field width
- INPUTS, 8, core input count
- OUTPUTS, 8, core output count
- MAX_IO, max(INPUTS, OUTPUTS), I/O slot count
- PAYLOAD_WIDTH, STREAM_WIDTH-1-ADDR_ROW_WIDTH-ADDR_COL_WIDTH-COMMAND_WIDTH, derived

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- node_row_i / node_col_i  in  ADDR_ROW_WIDTH / ADDR_COL_WIDTH  node identity
- msg_data_i  in  STREAM_WIDTH  inbound message
- msg_valid_i  in  1  inbound valid
- msg_ready_o  out  1  inbound ready
- byp_data_o  out  STREAM_WIDTH  forwarded message
- byp_dir_o  out  2  forward direction (DIRX_NORTH=0, EAST=1, SOUTH=2, WEST=3)
- byp_valid_o  out  1  forward valid
- byp_ready_i  in  1  forward ready
- map_io_o, map_input_o, map_remote_row_o, map_remote_col_o, map_remote_idx_o, map_slot_o, map_broadcast_o, map_seq_o  out  $clog2(MAX_IO), 1, ADDR_ROW_WIDTH, ADDR_COL_WIDTH, $clog2(OUTPUTS), 1, 1, 1  I/O mapping fields
- map_valid_o  out  1  mapping strobe
- signal_remote_row_o, signal_remote_col_o, signal_remote_idx_o, signal_state_o  out  ADDR_ROW_WIDTH, ADDR_COL_WIDTH, $clog2(OUTPUTS), 1  signal update fields
- signal_valid_o  out  1  signal strobe
- trigger_o  out  1  external trigger pulse to node control
- instr_data_o  out  PAYLOAD_WIDTH  instruction word
- instr_valid_o  out  1  instruction strobe

## Operation
- Message layout, MSB first: {bc, tgt_row, tgt_col, cmd, payload}.
- Command encodings: CMD_LOAD_INSTR=0, CMD_CFG_IO=1, CMD_SIG_STATE=2, CMD_CONTROL=3.
- Transfer rule: a message transfers on msg_valid_i && msg_ready_o.
- Ready: msg_ready_o = !rst_i && (!byp_valid_o || byp_ready_i). This is combinational and gates local and forwarded messages alike; head-of-line blocking is intentional.
- Local message: bc=1, or tgt_row==node_row_i && tgt_col==node_col_i.
- bc=1 is a one-hop neighbour broadcast. It is always consumed locally and never forwarded.
- Local decode by cmd:
  - CMD_SIG_STATE payload = {src_row, src_col, src_idx, state, zero pad}. Drives the signal_* fields and pulses signal_valid_o.
  - CMD_CFG_IO payload = {io, input, remote_row, remote_col, remote_idx, slot, broadcast, seq, zero pad}. Drives the map_* fields and pulses map_valid_o.
  - CMD_LOAD_INSTR: instr_data_o = payload; pulses instr_valid_o.
  - CMD_CONTROL: pulses trigger_o if payload[0]=1; otherwise the message is dropped silently.
- Non-local message: loaded unmodified into the bypass register.
- Forward direction, first match wins:
  - tgt_row < node_row → NORTH
  - tgt_row > node_row → SOUTH
  - tgt_col < node_col → WEST
  - else → EAST
- Bypass register: byp_valid_o clears on byp_ready_i. It reloads in the same cycle if a new non-local message transfers. byp_data_o and byp_dir_o stay stable while byp_valid_o && !byp_ready_i.
- Field values: the map_*, signal_* and instr_data_o fields hold their last value when not strobed.

## Timing
- Latency: a message transferring at edge k drives its strobe, or byp_valid_o, high in cycle k+1.
- Strobes (map_valid_o, signal_valid_o, instr_valid_o, trigger_o) are high for exactly one cycle per message.
- At most one strobe is high per cycle.
- Throughput is one message per cycle when the bypass path is not stalled.
- Reset value of every output register is zero, including byp_dir_o (NORTH). msg_ready_o is 0 while rst_i is high.
- Reset mid-operation: a pending bypass message is discarded, and no strobe fires in the cycle after reset.
- Simultaneous drain and load of the bypass register: the new message is valid next cycle with no bubble.

## Test plan
- Signal update: node (2,3), message 0x11C27600 (source (1,3), idx 5, state 1) → cycle+1: signal_valid_o=1, signal_remote_row_o=1, signal_remote_col_o=3, signal_remote_idx_o=5, signal_state_o=1; no other strobe.
- Forward: node (2,3), target (5,3), CMD_SIG_STATE → byp_valid_o=1, byp_dir_o=SOUTH(2), byp_data_o equal to the input. Target (2,0) → WEST(3). Target (2,7) → EAST(1).
- Backpressure: hold byp_ready_i=0 with one forwarded message pending → msg_ready_o=0. A following local message is not strobed until byp_ready_i=1, then strobes one cycle after transfer. byp_data_o is stable throughout.
- Broadcast: bc=1, target (0,0), CMD_CFG_IO with io=4, input=1, seq=1 → map_valid_o=1, map_io_o=4, map_input_o=1, map_seq_o=1; byp_valid_o stays 0.
- Streaming: ten back-to-back non-local messages with byp_ready_i=1 → ten consecutive byp_valid_o cycles, in order, no bubbles.
- Reset: assert rst_i with byp_valid_o=1 → next cycle all outputs 0, msg_ready_o=0; after deassert msg_ready_o=1.
